// File: rtl/bin2bcd32.sv
// bin2bcd32
// Sequential binary-to-packed-BCD converter using the shift-add-3
// (double-dabble) method, one binary bit per clock. Sits downstream of the
// 16x16 multiplier: its start/done handshake matches the multiplier's, so
// the multiplier's done/yout can drive start/bin_in directly.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, only sampled while idle
//   bin_in   in   [DIN_W-1:0] binary value, latched when start is accepted
//   busy     out  high while a conversion is in progress
//   done     out  one-cycle pulse, bcd_out just updated
//   bcd_out  out  [DIG_N*4-1:0] packed BCD, digit 0 (units) in [3:0],
//                 held until the next done

module bin2bcd32 #(
  parameter int DIN_W = 32,
  parameter int DIG_N = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIN_W-1:0]   bin_in,
  output logic               busy,
  output logic               done,
  output logic [DIG_N*4-1:0] bcd_out
);

  localparam int                CNT_W    = $clog2(DIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIN_W - 1);

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIN_W-1:0]     bin_q, bin_d;
  logic [DIG_N*4-1:0]   bcd_q, bcd_d;
  logic [DIG_N*4-1:0]   bcd_out_q, bcd_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DIG_N*4-1:0]   bcd_adj;
  logic [DIG_N*4-1:0]   bcd_shifted;

  // State register. Everything, including the held result, clears on reset
  // so an aborted conversion leaves no stale value on bcd_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      bcd_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bcd_out_q <= bcd_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. Each SHIFT cycle first corrects every digit >= 5 by +3
  // (all digits from the pre-edge value, independently), then shifts
  // {bcd, bin} left by one so the binary MSB enters the units digit.
  // done is cleared every cycle unless this is the completion edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    bcd_out_d   = bcd_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bcd_adj     = bcd_q;
    bcd_shifted = '0;

    for (int i = 0; i < DIG_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shifted = {bcd_adj[DIG_N*4-2:0], bin_q[DIN_W-1]};

    unique case (state_q)
      IDLE: begin
        // Accepting here also covers the cycle where done is high, which
        // gives back-to-back conversions with no idle gap.
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_shifted;
        bin_d = {bin_q[DIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_out_d = bcd_shifted;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_bin2bcd32.sv
// tb_bin2bcd32
// Directed-vector bench for bin2bcd32. Inputs are driven and outputs sampled
// on the falling edge, away from the rising edge the design uses.

module tb_bin2bcd32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [39:0] bcd_out;

  int nAsserts = 0;
  int nFails   = 0;

  int edges;
  int busyCycles;
  int doneCount;
  int gap;

  bin2bcd32 #(.DIN_W(32), .DIG_N(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One immediate assertion per comparison; failures are counted and reported
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start with a value on the falling edge, then follow the
  // conversion until done. edges counts rising edges from the accepting one
  // (inclusive) to the one that raises done; busyCycles counts sampled
  // cycles with busy high. Bounded so a dead design cannot hang the run.
  task automatic applyStimulus(input logic [31:0] val);
    @(negedge clk);
    bin_in = val;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    edges      = 1;
    busyCycles = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busyCycles++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_bcd",  64'(bcd_out), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero: latency and busy width
    applyStimulus(32'd0);
    checkOutput("zero_latency", 64'(edges), 64'd33);
    checkOutput("zero_busy_cycles", 64'(busyCycles), 64'd32);
    checkOutput("zero_bcd", 64'(bcd_out), 64'h0000000000);
    @(negedge clk);
    checkOutput("zero_done_pulse", 64'(done), 64'd0);

    // Multiplier's default product 65535*65535
    applyStimulus(32'd4294836225);
    checkOutput("mul_latency", 64'(edges), 64'd33);
    checkOutput("mul_done", 64'(done), 64'd1);
    checkOutput("mul_bcd", 64'(bcd_out), 64'h4294836225);
    @(negedge clk);
    checkOutput("mul_done_pulse", 64'(done), 64'd0);
    checkOutput("mul_bcd_held", 64'(bcd_out), 64'h4294836225);

    // Full-scale input
    applyStimulus(32'hFFFFFFFF);
    checkOutput("max_bcd", 64'(bcd_out), 64'h4294967295);

    applyStimulus(32'd12345);
    checkOutput("12345_bcd", 64'(bcd_out), 64'h0000012345);

    // Start of 100, then a second start with 999 ten cycles in: ignored
    @(negedge clk);
    bin_in = 32'd100;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mid_bcd_unchanged", 64'(bcd_out), 64'h0000012345);
    checkOutput("mid_busy", 64'(busy), 64'd1);
    bin_in = 32'd999;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    edges     = 11;
    doneCount = 0;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("ignore_latency", 64'(edges), 64'd33);
    checkOutput("ignore_bcd", 64'(bcd_out), 64'h0000000100);
    repeat (40) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("ignore_single_done", 64'(doneCount), 64'd0);
    checkOutput("ignore_bcd_held", 64'(bcd_out), 64'h0000000100);

    // start held high: 7 then 58, back-to-back
    @(negedge clk);
    bin_in = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    bin_in = 32'd58;
    edges  = 1;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("hold_first_latency", 64'(edges), 64'd33);
    checkOutput("hold_first_bcd", 64'(bcd_out), 64'h0000000007);
    gap = 0;
    @(negedge clk);
    gap++;
    while (!done && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    checkOutput("hold_gap", 64'(gap), 64'd33);
    checkOutput("hold_second_bcd", 64'(bcd_out), 64'h0000000058);

    // Reset at cycle 15 of a conversion
    @(negedge clk);
    bin_in = 32'hFFFFFFFF;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("abort_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_bcd",  64'(bcd_out), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    checkOutput("abort_bcd_stays", 64'(bcd_out), 64'd0);

    // Recovery after abort
    applyStimulus(32'd9);
    checkOutput("recover_latency", 64'(edges), 64'd33);
    checkOutput("recover_bcd", 64'(bcd_out), 64'h0000000009);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
